// File: rtl/neopixel_rx_if.sv
// Pixel-side bundle of the WS2812 receiver: raw data line in, decoded pixels and strobes out.
// NEOPIXEL_RX_PASSTHRU_EN adds the daisy-chain output dout.
interface neopixel_rx_if;
   logic        din;
   logic [23:0] color;
   logic [15:0] address;
   logic        pixel_valid;
   logic        frame_done;
   logic        overflow;
   logic        error;
`ifdef NEOPIXEL_RX_PASSTHRU_EN
   logic        dout;

   modport master (
      input  din,
      output color, address, pixel_valid, frame_done, overflow, error, dout
   );
   modport slave (
      output din,
      input  color, address, pixel_valid, frame_done, overflow, error, dout
   );
`else
   modport master (
      input  din,
      output color, address, pixel_valid, frame_done, overflow, error
   );
   modport slave (
      output din,
      input  color, address, pixel_valid, frame_done, overflow, error
   );
`endif
endinterface

// File: rtl/neopixel_rx.sv
// WS2812 one-wire receiver: recovers {R,G,B} pixels and their frame index from a NeoPixel line.
// Optional NEOPIXEL_RX_PASSTHRU_EN drives bus.dout with the line once NUM_LEDS pixels are consumed.
module neopixel_rx #(
   parameter int unsigned NUM_LEDS   = 64,
   parameter int unsigned T_MIN_HIGH = 5,
   parameter int unsigned T_THRESH   = 15,
   parameter int unsigned T_MAX_HIGH = 30,
   parameter int unsigned T_RESET    = 1250
) (
   input  logic          clk,
   input  logic          rst,
   neopixel_rx_if.master bus
);
   localparam int unsigned HI_W = $clog2(T_MAX_HIGH + 2);
   localparam int unsigned LO_W = $clog2(T_RESET + 1);

   localparam logic [HI_W-1:0] HI_MIN  = HI_W'(T_MIN_HIGH);
   localparam logic [HI_W-1:0] HI_THR  = HI_W'(T_THRESH);
   localparam logic [HI_W-1:0] HI_MAX  = HI_W'(T_MAX_HIGH);
   localparam logic [HI_W-1:0] HI_ONE  = HI_W'(1);
   localparam logic [LO_W-1:0] LO_LAST = LO_W'(T_RESET - 1);
   localparam logic [LO_W-1:0] LO_ONE  = LO_W'(1);
   localparam logic [15:0]     IDX_N   = 16'(NUM_LEDS);

   typedef enum logic [1:0] {HUNT, IDLE, HIGH, LOW} state_t;

   state_t          state;
   logic            s1, s2, s3;
   logic [HI_W-1:0] hi_cnt;
   logic [LO_W-1:0] lo_cnt;
   logic [4:0]      bit_cnt;
   logic [23:0]     shreg;
   logic [15:0]     pix_idx;

   logic        rise, fall, bit_val;
   logic [23:0] sh_next;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign bit_val = (hi_cnt >= HI_THR);
   assign sh_next = {shreg[22:0], bit_val};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= HUNT;
         s1              <= 1'b0;
         s2              <= 1'b0;
         s3              <= 1'b0;
         hi_cnt          <= '0;
         lo_cnt          <= '0;
         bit_cnt         <= '0;
         shreg           <= '0;
         pix_idx         <= '0;
         bus.color       <= '0;
         bus.address     <= '0;
         bus.pixel_valid <= 1'b0;
         bus.frame_done  <= 1'b0;
         bus.overflow    <= 1'b0;
         bus.error       <= 1'b0;
      end else begin
         s1 <= bus.din;
         s2 <= s1;
         s3 <= s2;
         bus.pixel_valid <= 1'b0;
         bus.frame_done  <= 1'b0;
         bus.error       <= 1'b0;

         case (state)
            HUNT: begin
               // Only a full reset gap re-arms the decoder; the aborted frame ends silently.
               if (s2) begin
                  lo_cnt <= '0;
               end else if (lo_cnt == LO_LAST) begin
                  lo_cnt       <= '0;
                  pix_idx      <= '0;
                  bus.overflow <= 1'b0;
                  state        <= IDLE;
               end else begin
                  lo_cnt <= lo_cnt + 1'b1;
               end
            end

            IDLE: begin
               if (rise) begin
                  hi_cnt  <= HI_ONE;
                  bit_cnt <= '0;
                  shreg   <= '0;
                  state   <= HIGH;
               end
            end

            HIGH: begin
               if (fall) begin
                  if (hi_cnt < HI_MIN || hi_cnt > HI_MAX) begin
                     bus.error <= 1'b1;
                     bit_cnt   <= '0;
                     shreg     <= '0;
                     lo_cnt    <= '0;
                     state     <= HUNT;
                  end else begin
                     shreg  <= sh_next;
                     lo_cnt <= LO_ONE;
                     state  <= LOW;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        // Wire order is G,R,B; present as {R,G,B}.
                        if (pix_idx < IDX_N) begin
                           bus.color       <= {sh_next[15:8], sh_next[23:16], sh_next[7:0]};
                           bus.address     <= pix_idx;
                           bus.pixel_valid <= 1'b1;
                        end else begin
                           bus.overflow <= 1'b1;
                        end
                        if (pix_idx != 16'hFFFF) pix_idx <= pix_idx + 16'd1;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end else if (hi_cnt >= HI_MAX) begin
                  bus.error <= 1'b1;
                  bit_cnt   <= '0;
                  shreg     <= '0;
                  lo_cnt    <= '0;
                  state     <= HUNT;
               end else begin
                  hi_cnt <= hi_cnt + 1'b1;
               end
            end

            LOW: begin
               if (rise) begin
                  hi_cnt <= HI_ONE;
                  state  <= HIGH;
               end else if (lo_cnt == LO_LAST) begin
                  if (bit_cnt != '0)  bus.error      <= 1'b1;
                  if (pix_idx != '0)  bus.frame_done <= 1'b1;
                  pix_idx      <= '0;
                  bus.overflow <= 1'b0;
                  bit_cnt      <= '0;
                  shreg        <= '0;
                  lo_cnt       <= '0;
                  state        <= IDLE;
               end else begin
                  lo_cnt <= lo_cnt + 1'b1;
               end
            end

            default: state <= HUNT;
         endcase
      end
   end

`ifdef NEOPIXEL_RX_PASSTHRU_EN
   // pix_idx only reaches NUM_LEDS inside a live frame; HUNT/IDLE force the line quiet.
   assign bus.dout = s2 && (pix_idx >= IDX_N) && (state == HIGH || state == LOW);
`endif

endmodule
